uart_tx_cfg: RTL
================

// Module: uart_tx_cfg
// PURPOSE
//  Runtime-configurable UART transmitter: 5-8 data bits, none/odd/even parity, 1 or 2 stop bits,
//  and a runtime baud divisor. An internal TX FIFO decouples the producer from line rate.
//  Also generates a line break. Second-generation board console/debug TX; sits between fabric
//  logic and the PL txd pin.
// PARAMETERS
//  CLK_HZ      125_000_000  fabric clock frequency
//  BAUD        115_200      default baud; BAUD_DIV = (CLK_HZ + BAUD/2) / BAUD, used when cfg_div < 2
//  DIV_W       16           width of cfg_div and of the bit-period counter; BAUD_DIV must fit
//  FIFO_DEPTH  16           TX FIFO entries; power of two, >= 2
// PORTS
//  clk            in   1            clock; single clock domain
//  rst            in   1            synchronous reset, active-high
//  valid          in   1            producer byte valid
//  data           in   8            byte; bits above the configured data length are ignored
//  ready          out  1            ~fifo_full; accept when valid & ready
//  cfg_div        in   DIV_W        clocks per bit; values 0 or 1 select BAUD_DIV
//  cfg_data_bits  in   2            data bits = 5 + cfg_data_bits (0->5 .. 3->8)
//  cfg_parity     in   2            0 none, 1 odd, 2 even, 3 none
//  cfg_stop2      in   1            1 = two stop bits
//  send_break     in   1            level; hold txd low while asserted (see BEHAVIOUR)
//  txd            out  1            serial line, idles high, registered
//  busy           out  1            frame/break/mark in progress OR FIFO non-empty
//  fifo_level     out  $clog2(FIFO_DEPTH)+1   entries currently queued
// BEHAVIOUR
//  Reset: txd=1, FIFO flushed, fifo_level=0, ready=1, busy=0, FSM=IDLE. Applies even mid-frame:
//   the frame is aborted and txd is high the cycle after reset.
//  FIFO: write on valid&ready; pop only by the serializer. Simultaneous push and pop keeps the
//   level unchanged. No fall-through: a word written at edge N can be popped at edge N+1 at the
//   earliest.
//  Config latch: cfg_* are sampled into shadow registers at the pop edge. Changes mid-frame
//   affect only the next frame.
//  div_eff = (cfg_div < 2) ? BAUD_DIV : cfg_div. Every bit (start, data, parity, stop) lasts
//   exactly div_eff clocks.
//  FSM:
//   IDLE:   if send_break -> BREAK (txd<=0); else if !empty -> pop, txd<=0, START.
//   START:  after div_eff clocks -> DATA.
//   DATA:   n bits, LSB first.
//   PARITY: 1 bit; skipped when parity is none. Odd: bit = ~^d[n-1:0]. Even: bit = ^d[n-1:0].
//   STOP:   1 or 2 bits of 1.
//   End of STOP: if send_break -> BREAK; else if !empty -> pop, START directly (zero idle gap);
//    else -> IDLE.
//   BREAK:  txd=0 while send_break. On release -> MARK (txd=1) for one div_eff bit time -> IDLE.
//  Break rules:
//   - Break requested mid-frame does not truncate the frame; BREAK is entered after the last
//     stop bit.
//   - The FIFO is not popped during BREAK or MARK.
//  Frame length = (1 + n + p + s) * div_eff clocks.
//  Counter rules:
//   - Bit counter loads div_eff-1 and counts down to 0.
//   - div_eff is DIV_W wide, with no overflow.
//  Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE drives the start
//   bit from edge N+1.
// STRUCTURE
//  Package uart_pkg: parity_e {PAR_NONE, PAR_ODD, PAR_EVEN}, tx_state_e, function baud_div(CLK_HZ, BAUD).
//  Sub-module uart_sync_fifo #(WIDTH=8, DEPTH): push/pop/full/empty/level, registered read data.
//  Top: FSM, shadow config, bit-period counter, bit index, shift register, parity accumulator.
// TESTING  (CLK_HZ=1000, BAUD=100 -> BAUD_DIV=10; FIFO_DEPTH=4 unless noted)
//  1 cfg 8N1, cfg_div=0, push 0x55 -> txd 0,1,0,1,0,1,0,1,0,1, each 10 clk; busy falls at clk 100.
//  2 cfg 7E2, cfg_div=4, push 0xC1 -> start, 1,0,0,0,0,0,1, parity 0, stop 1,1; 44 clk total.
//  3 cfg 5O1, cfg_div=3, push 0xFF -> five 1s, parity 0, one stop; 24 clk total.
//  4 push 6 bytes on consecutive clocks -> 5 accepted, ready low on 6th; all 5 emitted in order,
//    no idle between frames.
//  5 assert send_break mid-frame 2 of 3 -> frame 2 completes, txd low for the break, then 1 bit mark,
//    then frame 3.
//  6 rst during data bit 3; change cfg mid-frame -> txd=1, level=0 after reset;
//    cfg takes effect only on the next frame.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the configurable UART transmitter.
//   parity_e       : parity mode held in the per-frame shadow configuration
//   tx_state_e     : serializer state encoding
//   baud_div()     : rounded clocks-per-bit for a clock/baud pair
//   decode_parity(): maps the 2-bit cfg_parity code onto parity_e
//   parity_bit()   : parity bit from the XOR accumulator of the data bits
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5,
    S_MARK   = 3'd6
  } tx_state_e;

  // Nearest integer clocks per bit: (clk_hz + baud/2) / baud.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + (baud / 32'sd2)) / baud;
  endfunction

  // Code 3 is treated as "no parity", like code 0.
  function automatic parity_e decode_parity(input logic [1:0] code);
    parity_e mode;
    case (code)
      2'd1:    mode = PAR_ODD;
      2'd2:    mode = PAR_EVEN;
      default: mode = PAR_NONE;
    endcase
    return mode;
  endfunction

  // acc is the XOR of the transmitted data bits. Odd parity makes the total
  // count of ones odd, so it is the inverted accumulator.
  function automatic logic parity_bit(input parity_e mode, input logic acc);
    logic bit_v;
    case (mode)
      PAR_ODD:  bit_v = ~acc;
      PAR_EVEN: bit_v = acc;
      default:  bit_v = 1'b0;
    endcase
    return bit_v;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with registered read data. A pop loads rd_data_o with the
// head entry on the pop edge, so a word written at edge N is first poppable at
// edge N+1 (no fall-through).
// Ports:
//   clk, rst          clock, synchronous active-high reset (flushes contents)
//   push_i/wr_data_i  write request and data; ignored when full
//   pop_i             read request; ignored when empty
//   rd_data_o         word removed by the most recent pop
//   full_o, empty_o   occupancy flags
//   level_o           number of entries queued
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (level_q == FULL_LEVEL);
  assign empty_o   = (level_q == {(AW+1){1'b0}});
  assign level_o   = level_q;
  assign rd_data_o = rd_data_q;
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers, occupancy and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      level_q   <= {(AW+1){1'b0}};
      rd_data_q <= {WIDTH{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1'b1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
      // Simultaneous push and pop leaves the level unchanged.
      case ({do_push_s, do_pop_s})
        2'b10:   level_q <= level_q + {{AW{1'b0}}, 1'b1};
        2'b01:   level_q <= level_q - {{AW{1'b0}}, 1'b1};
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
// Runtime-configurable UART transmitter with TX FIFO and line-break support.
// Ports:
//   clk, rst        clock, synchronous active-high reset (aborts any frame)
//   valid, data     producer byte; accepted when valid & ready
//   ready           FIFO not full
//   cfg_div         clocks per bit; 0 or 1 selects the BAUD-derived default
//   cfg_data_bits   data length = 5 + cfg_data_bits
//   cfg_parity      0/3 none, 1 odd, 2 even
//   cfg_stop2       two stop bits when set
//   send_break      level request to hold the line low between frames
//   txd             registered serial output, idles high
//   busy            serializer active or bytes still queued
//   fifo_level      entries currently queued
// Config is captured into shadow registers when a byte is popped, so cfg_*
// may change at any time without disturbing the frame on the wire.
// -----------------------------------------------------------------------------
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 125_000_000,
  parameter int BAUD       = 115_200,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid,
  input  logic [7:0]                  data,
  output logic                        ready,
  input  logic [DIV_W-1:0]            cfg_div,
  input  logic [1:0]                  cfg_data_bits,
  input  logic [1:0]                  cfg_parity,
  input  logic                        cfg_stop2,
  input  logic                        send_break,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int               BAUD_DIV_I = baud_div(CLK_HZ, BAUD);
  localparam logic [DIV_W-1:0] BAUD_DIV   = BAUD_DIV_I[DIV_W-1:0];

  // Serializer state and datapath registers
  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_acc_q, par_acc_d;
  logic             txd_q, txd_d;

  // Shadow configuration for the frame in flight
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       dbits_q, dbits_d;
  parity_e          parity_q, parity_d;
  logic             stop2_q, stop2_d;

  // FIFO interface
  logic             fifo_push_s;
  logic             fifo_pop_s;
  logic [7:0]       fifo_rdata_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;

  logic [DIV_W-1:0] div_live_s;
  logic [DIV_W-1:0] div_m1_s;
  logic [2:0]       last_idx_s;
  logic             bit_end_s;
  logic             launch_s;

  assign ready       = ~fifo_full_s;
  assign fifo_push_s = valid & ~fifo_full_s;
  assign txd         = txd_q;
  assign busy        = (state_q != S_IDLE) | ~fifo_empty_s;

  assign div_live_s = (cfg_div < DIV_W'(2'd2)) ? BAUD_DIV : cfg_div;
  assign div_m1_s   = div_q - DIV_W'(1'b1);
  assign last_idx_s = 3'd4 + {1'b0, dbits_q};
  assign bit_end_s  = (cnt_q == {DIV_W{1'b0}});

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (fifo_push_s),
    .wr_data_i (data),
    .pop_i     (fifo_pop_s),
    .rd_data_o (fifo_rdata_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .level_o   (fifo_level)
  );

  // Next-state, line level and datapath updates for the serializer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_acc_d  = par_acc_q;
    txd_d      = txd_q;
    div_d      = div_q;
    dbits_d    = dbits_q;
    parity_d   = parity_q;
    stop2_d    = stop2_q;
    fifo_pop_s = 1'b0;
    launch_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (send_break) begin
          state_d = S_BREAK;
          txd_d   = 1'b0;
        end else if (!fifo_empty_s) begin
          launch_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      // The popped byte lands in the FIFO read register on the pop edge and
      // stays put until the next pop, so it is picked up at the end of START.
      S_START: begin
        if (bit_end_s) begin
          state_d   = S_DATA;
          shift_d   = fifo_rdata_s;
          txd_d     = fifo_rdata_s[0];
          par_acc_d = fifo_rdata_s[0];
          idx_d     = 3'd0;
          cnt_d     = div_m1_s;
        end else begin
          cnt_d = cnt_q - DIV_W'(1'b1);
        end
      end

      S_DATA: begin
        if (bit_end_s) begin
          cnt_d = div_m1_s;
          if (idx_q == last_idx_s) begin
            if (parity_q == PAR_NONE) begin
              state_d = S_STOP;
              txd_d   = 1'b1;
              idx_d   = 3'd0;
            end else begin
              state_d = S_PARITY;
              txd_d   = parity_bit(parity_q, par_acc_q);
            end
          end else begin
            idx_d     = idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
            par_acc_d = par_acc_q ^ shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1'b1);
        end
      end

      S_PARITY: begin
        if (bit_end_s) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
          idx_d   = 3'd0;
          cnt_d   = div_m1_s;
        end else begin
          cnt_d = cnt_q - DIV_W'(1'b1);
        end
      end

      // idx counts stop bits here. A pending break wins over queued data, and
      // queued data starts the next frame with no idle gap.
      S_STOP: begin
        txd_d = 1'b1;
        if (bit_end_s) begin
          if (stop2_q && (idx_q == 3'd0)) begin
            idx_d = 3'd1;
            cnt_d = div_m1_s;
          end else if (send_break) begin
            state_d = S_BREAK;
            txd_d   = 1'b0;
          end else if (!fifo_empty_s) begin
            launch_s = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1'b1);
        end
      end

      S_BREAK: begin
        if (send_break) begin
          txd_d = 1'b0;
        end else begin
          state_d = S_MARK;
          txd_d   = 1'b1;
          cnt_d   = div_live_s - DIV_W'(1'b1);
        end
      end

      S_MARK: begin
        txd_d = 1'b1;
        if (bit_end_s) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - DIV_W'(1'b1);
        end
      end

      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Frame launch: pop the head byte, snapshot the config, drive the start bit.
    if (launch_s) begin
      fifo_pop_s = 1'b1;
      state_d    = S_START;
      txd_d      = 1'b0;
      div_d      = div_live_s;
      dbits_d    = cfg_data_bits;
      parity_d   = decode_parity(cfg_parity);
      stop2_d    = cfg_stop2;
      cnt_d      = div_live_s - DIV_W'(1'b1);
      idx_d      = 3'd0;
    end else begin
      fifo_pop_s = 1'b0;
    end
  end

  // Serializer and shadow-config registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= {DIV_W{1'b0}};
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      par_acc_q <= 1'b0;
      txd_q     <= 1'b1;
      div_q     <= {DIV_W{1'b0}};
      dbits_q   <= 2'd0;
      parity_q  <= PAR_NONE;
      stop2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_acc_q <= par_acc_d;
      txd_q     <= txd_d;
      div_q     <= div_d;
      dbits_q   <= dbits_d;
      parity_q  <= parity_d;
      stop2_q   <= stop2_d;
    end
  end

endmodule
